// File: rtl/processor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : processor_pkg
//  Description : Shared definitions for the PC sequencer: datapath word width,
//                sequencer state encoding and the return-address helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package processor_pkg;

  localparam int WORD_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALTED  = 3'd4
  } seq_state_e;

  // Address of the instruction following a call; wraps 16'hFFFF -> 16'h0000.
  function automatic logic [WORD_WIDTH-1:0] return_addr(input logic [WORD_WIDTH-1:0] pc);
    return pc + WORD_WIDTH'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_if
//  Description : Control/status bundle between the instruction pipeline and
//                the PC sequencer.
//                slave  : sequencer side (decode inputs in, PC/fetch controls out)
//                master : pipeline side (opposite directions)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if;
  import processor_pkg::*;

  logic                  start;
  logic                  mem_ready;
  logic                  stall;
  logic                  halt_req;
  logic                  branch_req;
  logic                  branch_cond;
  logic [WORD_WIDTH-1:0] branch_target;
  logic                  call_req;
  logic                  ret_req;
  logic [WORD_WIDTH-1:0] pc_value;

  logic                  imem_req;
  logic                  ir_load;
  logic                  pc_enable;
  logic                  pc_load;
  logic [WORD_WIDTH-1:0] pc_new;
  logic                  busy;
  logic                  halted;
  logic                  stack_overflow;
  logic                  stack_underflow;

  modport slave (
    input  start, mem_ready, stall, halt_req, branch_req, branch_cond,
           branch_target, call_req, ret_req, pc_value,
    output imem_req, ir_load, pc_enable, pc_load, pc_new, busy, halted,
           stack_overflow, stack_underflow
  );

  modport master (
    output start, mem_ready, stall, halt_req, branch_req, branch_cond,
           branch_target, call_req, ret_req, pc_value,
    input  imem_req, ir_load, pc_enable, pc_load, pc_new, busy, halted,
           stack_overflow, stack_underflow
  );

endinterface
`default_nettype wire

// File: rtl/return_stack.sv
`default_nettype none
// ============================================================================
//  Module      : return_stack
//  Description : DEPTH-entry LIFO of return addresses.
//  Ports       : clock, clear (sync, active-high)
//                push_i / pop_i  - push data_i / discard top entry
//                data_o          - current top entry (valid when !empty_o)
//                full_o, empty_o - occupancy status
//                A push while full or a pop while empty is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;

  // count_q is both the occupancy and the next free slot.
  assign wr_ptr  = PTR_W'(count_q);
  assign top_ptr = PTR_W'(count_q - CNT_W'(1));
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[top_ptr];

  always_ff @(posedge clock) begin
    if (clear) begin
      count_q <= '0;
    end else if (push_i && !full_o) begin
      count_q <= count_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  // Storage needs no reset: entries above count_q are never read.
  always_ff @(posedge clock) begin
    if (push_i && !full_o) begin
      mem_q[wr_ptr] <= data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Fetch/decode/execute sequencer driving the PC register.
//                IDLE -> FETCH -> DECODE -> EXECUTE -> FETCH ..., HALTED on
//                halt_req. EXECUTE priority: halt > taken branch > call > ret
//                > sequential increment.
//  Ports       : clock, clear (sync, active-high), bus (pc_sequencer_if.slave)
//  Config      : CALL_STACK_EN - enables the STACK_DEPTH-entry return stack;
//                when undefined call_req/ret_req are ignored and the stack
//                error flags read 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import processor_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic           clock,
  input  logic           clear,
  pc_sequencer_if.slave  bus
);

  seq_state_e state_q, state_d;
  logic       taken;

  assign taken = bus.branch_req & bus.branch_cond;

`ifdef CALL_STACK_EN
  logic                  push, pop;
  logic                  stk_full, stk_empty;
  logic [WORD_WIDTH-1:0] stk_top;
  logic                  ovf_q, ovf_d, unf_q, unf_d;

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (WORD_WIDTH)
  ) u_return_stack (
    .clock   (clock),
    .clear   (clear),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (return_addr(bus.pc_value)),
    .data_o  (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus.call_req, bus.ret_req, bus.pc_value, (STACK_DEPTH > 0)};

  assign bus.stack_overflow  = 1'b0;
  assign bus.stack_underflow = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.imem_req  = 1'b0;
    bus.ir_load   = 1'b0;
    bus.pc_enable = 1'b0;
    bus.pc_load   = 1'b0;
    bus.pc_new    = '0;
    bus.busy      = 1'b0;
    bus.halted    = 1'b0;
`ifdef CALL_STACK_EN
    push  = 1'b0;
    pop   = 1'b0;
    ovf_d = ovf_q;
    unf_d = unf_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        bus.imem_req = 1'b1;
        bus.busy     = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_load = 1'b1;
          state_d     = ST_DECODE;
        end
      end

      ST_DECODE: begin
        bus.busy = 1'b1;
        state_d  = ST_EXECUTE;
      end

      ST_EXECUTE: begin
        bus.busy = 1'b1;
        if (!bus.stall) begin
          if (bus.halt_req) begin
            state_d = ST_HALTED;
          end else begin
            state_d       = ST_FETCH;
            bus.pc_enable = 1'b1;
            if (taken) begin
              bus.pc_load = 1'b1;
              bus.pc_new  = bus.branch_target;
            end
`ifdef CALL_STACK_EN
            // A call with a full stack falls back to a plain increment and
            // does not let a simultaneous ret through.
            else if (bus.call_req) begin
              if (stk_full) begin
                ovf_d = 1'b1;
              end else begin
                push        = 1'b1;
                bus.pc_load = 1'b1;
                bus.pc_new  = bus.branch_target;
              end
            end else if (bus.ret_req) begin
              if (stk_empty) begin
                unf_d = 1'b1;
              end else begin
                pop         = 1'b1;
                bus.pc_load = 1'b1;
                bus.pc_new  = stk_top;
              end
            end
`endif
          end
        end
      end

      ST_HALTED: begin
        bus.halted = 1'b1;
        if (bus.start) state_d = ST_FETCH;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter STACK_DEPTH, default 4, number of return-address stack entries; used only with CALL_STACK_EN.
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 clear  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  leaves IDLE or HALTED and begins fetching.
REQ-005 mem_ready  input  1  instruction memory returns a valid word this cycle.
REQ-006 stall  input  1  holds EXECUTE; no PC update.
REQ-007 halt_req  input  1  stop after the current instruction.
REQ-008 branch_req / branch_cond  input  1 each  branch decoded / condition true.
REQ-009 branch_target  input  16  absolute target for a branch or call.
REQ-010 call_req / ret_req  input  1 each  subroutine call / return decoded.
REQ-011 pc_value  input  16  current PC register value.
REQ-012 imem_req  output  1  instruction fetch request.
REQ-013 ir_load  output  1  instruction register capture strobe.
REQ-014 pc_enable / pc_load  output  1 each  drive the PC register's enable and load.
REQ-015 pc_new  output  16  PC load value.
REQ-016 busy / halted  output  1 each  status.
REQ-017 stack_overflow / stack_underflow  output  1 each  sticky error flags.

Function
REQ-018 States: IDLE, FETCH, DECODE, EXECUTE, HALTED; one-hot or binary encoding is allowed, and the behaviour SHALL be identical either way.
REQ-019 IDLE: all outputs 0; start=1 -> FETCH on the next edge.
REQ-020 FETCH: imem_req=1; mem_ready=1 -> ir_load=1 in the same cycle and DECODE next; mem_ready=0 -> remain in FETCH with no timeout.
REQ-021 DECODE: one cycle, no outputs asserted; -> EXECUTE.
REQ-022 EXECUTE with stall=1: pc_enable=0; remain in EXECUTE; inputs are re-evaluated each cycle.
REQ-023 EXECUTE with stall=0 uses priority halt_req > taken branch > call > ret > sequential; the action completes in the same cycle, and the block goes to FETCH next (HALTED if halt_req).
REQ-024 halt_req: pc_enable=0; -> HALTED.
REQ-025 Taken branch (branch_req & branch_cond): pc_enable=1, pc_load=1, pc_new=branch_target; branch_req with branch_cond=0 is handled as sequential.
REQ-026 Sequential: pc_enable=1, pc_load=0 (the PC increments itself).
REQ-027 pc_new=0 whenever pc_load=0; pc_enable/pc_load are combinational from state and inputs, never registered.
REQ-028 HALTED: halted=1, other outputs 0; start=1 -> FETCH (resume at current PC).
REQ-029 busy=1 in FETCH, DECODE and EXECUTE; 0 otherwise.
REQ-030 Return address = pc_value+1 modulo 2^16 (16'hFFFF -> 16'h0000).

Reset
REQ-031 clear=1 at any edge, in any state (including mid-stall or mid-fetch), SHALL force IDLE, an empty stack, and both sticky flags to 0, taking priority over all other inputs.
REQ-032 In the cycle after clear, every output SHALL be 0.

Configuration
REQ-033 Macro CALL_STACK_EN defined: STACK_DEPTH-entry LIFO; call pushes the return address and loads branch_target; ret pops and loads the popped value into pc_new.
REQ-034 Call when full: no push, sequential action, stack_overflow set; ret when empty: sequential action, stack_underflow set.
REQ-035 A push and a pop SHALL never occur in the same cycle (priority rule REQ-023).
REQ-036 Macro absent: call_req/ret_req ports are present but ignored (sequential action); no stack storage; both flags are tied to 0.

Structure
REQ-037 Shared package processor_pkg SHALL hold the state encodings and the constant WORD_WIDTH=16.
REQ-038 Sub-module return_stack (push, pop, data in/out, full, empty) SHALL be instantiated only under CALL_STACK_EN.

Verification
REQ-039 clear, start, mem_ready=1, no branches -> FETCH/DECODE/EXECUTE every 3 cycles; pc_enable=1, pc_load=0 once per instruction.
REQ-040 EXECUTE with branch_req=1, branch_cond=1, branch_target=16'h0040 -> pc_load=1, pc_new=16'h0040 in that cycle; the same inputs with branch_cond=0 -> pc_load=0.
REQ-041 mem_ready held 0 for 5 cycles in FETCH, then stall=1 for 3 cycles in EXECUTE -> ir_load only when mem_ready=1; pc_enable=0 throughout the stall.
REQ-042 CALL_STACK_EN, STACK_DEPTH=4: 5 calls at pc_value=16'hFFFF -> the first 4 push 16'h0000, the 5th sets stack_overflow; then 5 rets -> 4 loads of 16'h0000, the 5th sets stack_underflow.
REQ-043 halt_req and branch_req both asserted in EXECUTE -> halted=1, pc_enable=0; start -> FETCH.
REQ-044 clear asserted during FETCH with flags set -> next cycle all outputs 0, state IDLE, flags cleared.
